inv_sub_bytes: RTL and testbench
================================

# inv_sub_bytes

Sequential AES InvSubBytes engine for the decryption datapath. It accepts a 128-bit cipher state over a valid/ready handshake and replaces every byte with its inverse S-box value, where InvSbox(SubBytes(x)) = x for all 256 byte values. Bytes are substituted a few per cycle through a shared inverse S-box lookup, which trades latency for area. It sits between InvShiftRows and AddRoundKey in the inverse round, and returns its result over a second valid/ready handshake.

## Interface
- BYTES_PER_CYCLE, 4, number of bytes substituted per cycle; legal values 1, 2, 4, 8, 16; PASSES = 16 / BYTES_PER_CYCLE
- clk  input  1  clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  state_in holds a block to process
- in_ready  output  1  block accepts a new block this cycle
- state_in  input  128  input state; byte k = state_in[127-8k -: 8], k = 0..15
- out_valid  output  1  state_out holds a finished block
- out_ready  input  1  consumer takes state_out this cycle
- state_out  output  128  substituted state, same byte ordering as state_in
- busy  output  1  high while the FSM is not in IDLE

## Operation
- Inverse S-box: a 256-entry combinational table, the exact inverse of the AES forward S-box. Example entries: 63→00, 7c→01, 16→ff, 00→52, 52→48, ed→53. BYTES_PER_CYCLE copies of the table are instantiated.
- Internal registers:
  - st_reg, 128 bits, holds the state being processed
  - pass_cnt, width clog2(PASSES) with a minimum of 1 bit
  - 2-bit FSM
- IDLE:
  - in_ready = 1.
  - When in_valid = 1, latch state_in into st_reg, clear pass_cnt and go to BUSY.
- BUSY:
  - in_ready = 0.
  - Each cycle, replace bytes k = pass_cnt*BYTES_PER_CYCLE through pass_cnt*BYTES_PER_CYCLE + BYTES_PER_CYCLE - 1 of st_reg in place with InvSbox of their current value.
  - Increment pass_cnt.
  - On the pass where pass_cnt = PASSES-1, go to DONE and wrap pass_cnt to 0.
- DONE:
  - out_valid = 1, state_out = st_reg, in_ready = 0.
  - When out_ready = 1, go to IDLE.
- Byte values are treated as opaque 8-bit table indices; there is no arithmetic and no carry. Each byte is substituted exactly once per block.
- in_ready, out_valid and busy are decoded from the FSM state only. No output depends combinationally on in_valid or out_ready.
- state_out is driven directly from st_reg. It is only meaningful while out_valid = 1.
- Only one block is in flight at a time. A new block is not accepted in the DONE cycle, even when out_ready = 1.

## Timing
- Reset (rst_n low, asynchronous):
  - FSM = IDLE, st_reg = 0, pass_cnt = 0.
  - Outputs: out_valid = 0, busy = 0, state_out = 0, in_ready = 1.
- Reset asserted mid-BUSY or mid-DONE aborts the block and discards it. No out_valid pulse is produced for that block.
- Acceptance: at clock edge E0, with in_valid = 1 in IDLE.
- BUSY passes: edges E1 through E(PASSES).
- out_valid rises after edge E(PASSES). For BYTES_PER_CYCLE = 4 this is 4 cycles after acceptance; for 1 it is 16; for 16 it is 1.
- With out_ready held high, the minimum cycle time per block is PASSES + 2 edges (accept, PASSES passes, hand-off). in_ready re-asserts in the cycle after the hand-off edge.
- Back-pressure: while DONE and out_ready = 0, out_valid and state_out hold stable indefinitely.
- in_valid and state_in are ignored outside IDLE. Changes to state_in after acceptance have no effect on the block in flight.

## Test plan
- All-0x63 block: state_in = 128'h6363…63 with BYTES_PER_CYCLE = 4 -> state_out = 128'h0, with out_valid high exactly 4 cycles after the acceptance edge.
- Forward/inverse pair: state_in = 128'h637c777bf26b6fc53001672bfed7ab76 -> state_out = 128'h000102030405060708090a0b0c0d0e0f. Repeat with BYTES_PER_CYCLE = 1, 2, 8 and 16; latency must be 16, 8, 2 and 1 cycles respectively.
- Exhaustive coverage: 16 blocks whose bytes are SubBytes(0x00) through SubBytes(0xff) in order -> each output byte equals its original index. Spot-checks: 52→48, 00→52, 16→ff.
- Back-pressure: hold out_ready = 0 for 10 cycles after out_valid rises -> out_valid stays 1, state_out is unchanged, in_ready = 0, busy = 1. Raise out_ready for 1 cycle -> IDLE on the next edge with in_ready = 1.
- Reset mid-BUSY: pull rst_n low 2 cycles after acceptance -> out_valid = 0, state_out = 0, in_ready = 1 immediately. Then send all-0x63 -> all-0x00 returned with normal latency.
- Streaming: in_valid and out_ready held high with new data on every acceptance -> exactly one block accepted per PASSES + 2 cycles, with no dropped or duplicated out_valid pulses.

Source files
------------

// File: rtl/inv_sub_bytes.sv
// AES InvSubBytes engine: a 128-bit state is substituted BYTES_PER_CYCLE bytes
// per cycle through shared inverse S-box lanes, with valid/ready on both sides.

module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Full 256-entry inverse of the AES forward S-box.
  always_comb begin
    y = 8'h00;
    case (a)
      8'h00: y = 8'h52; 8'h01: y = 8'h09; 8'h02: y = 8'h6a; 8'h03: y = 8'hd5;
      8'h04: y = 8'h30; 8'h05: y = 8'h36; 8'h06: y = 8'ha5; 8'h07: y = 8'h38;
      8'h08: y = 8'hbf; 8'h09: y = 8'h40; 8'h0a: y = 8'ha3; 8'h0b: y = 8'h9e;
      8'h0c: y = 8'h81; 8'h0d: y = 8'hf3; 8'h0e: y = 8'hd7; 8'h0f: y = 8'hfb;
      8'h10: y = 8'h7c; 8'h11: y = 8'he3; 8'h12: y = 8'h39; 8'h13: y = 8'h82;
      8'h14: y = 8'h9b; 8'h15: y = 8'h2f; 8'h16: y = 8'hff; 8'h17: y = 8'h87;
      8'h18: y = 8'h34; 8'h19: y = 8'h8e; 8'h1a: y = 8'h43; 8'h1b: y = 8'h44;
      8'h1c: y = 8'hc4; 8'h1d: y = 8'hde; 8'h1e: y = 8'he9; 8'h1f: y = 8'hcb;
      8'h20: y = 8'h54; 8'h21: y = 8'h7b; 8'h22: y = 8'h94; 8'h23: y = 8'h32;
      8'h24: y = 8'ha6; 8'h25: y = 8'hc2; 8'h26: y = 8'h23; 8'h27: y = 8'h3d;
      8'h28: y = 8'hee; 8'h29: y = 8'h4c; 8'h2a: y = 8'h95; 8'h2b: y = 8'h0b;
      8'h2c: y = 8'h42; 8'h2d: y = 8'hfa; 8'h2e: y = 8'hc3; 8'h2f: y = 8'h4e;
      8'h30: y = 8'h08; 8'h31: y = 8'h2e; 8'h32: y = 8'ha1; 8'h33: y = 8'h66;
      8'h34: y = 8'h28; 8'h35: y = 8'hd9; 8'h36: y = 8'h24; 8'h37: y = 8'hb2;
      8'h38: y = 8'h76; 8'h39: y = 8'h5b; 8'h3a: y = 8'ha2; 8'h3b: y = 8'h49;
      8'h3c: y = 8'h6d; 8'h3d: y = 8'h8b; 8'h3e: y = 8'hd1; 8'h3f: y = 8'h25;
      8'h40: y = 8'h72; 8'h41: y = 8'hf8; 8'h42: y = 8'hf6; 8'h43: y = 8'h64;
      8'h44: y = 8'h86; 8'h45: y = 8'h68; 8'h46: y = 8'h98; 8'h47: y = 8'h16;
      8'h48: y = 8'hd4; 8'h49: y = 8'ha4; 8'h4a: y = 8'h5c; 8'h4b: y = 8'hcc;
      8'h4c: y = 8'h5d; 8'h4d: y = 8'h65; 8'h4e: y = 8'hb6; 8'h4f: y = 8'h92;
      8'h50: y = 8'h6c; 8'h51: y = 8'h70; 8'h52: y = 8'h48; 8'h53: y = 8'h50;
      8'h54: y = 8'hfd; 8'h55: y = 8'hed; 8'h56: y = 8'hb9; 8'h57: y = 8'hda;
      8'h58: y = 8'h5e; 8'h59: y = 8'h15; 8'h5a: y = 8'h46; 8'h5b: y = 8'h57;
      8'h5c: y = 8'ha7; 8'h5d: y = 8'h8d; 8'h5e: y = 8'h9d; 8'h5f: y = 8'h84;
      8'h60: y = 8'h90; 8'h61: y = 8'hd8; 8'h62: y = 8'hab; 8'h63: y = 8'h00;
      8'h64: y = 8'h8c; 8'h65: y = 8'hbc; 8'h66: y = 8'hd3; 8'h67: y = 8'h0a;
      8'h68: y = 8'hf7; 8'h69: y = 8'he4; 8'h6a: y = 8'h58; 8'h6b: y = 8'h05;
      8'h6c: y = 8'hb8; 8'h6d: y = 8'hb3; 8'h6e: y = 8'h45; 8'h6f: y = 8'h06;
      8'h70: y = 8'hd0; 8'h71: y = 8'h2c; 8'h72: y = 8'h1e; 8'h73: y = 8'h8f;
      8'h74: y = 8'hca; 8'h75: y = 8'h3f; 8'h76: y = 8'h0f; 8'h77: y = 8'h02;
      8'h78: y = 8'hc1; 8'h79: y = 8'haf; 8'h7a: y = 8'hbd; 8'h7b: y = 8'h03;
      8'h7c: y = 8'h01; 8'h7d: y = 8'h13; 8'h7e: y = 8'h8a; 8'h7f: y = 8'h6b;
      8'h80: y = 8'h3a; 8'h81: y = 8'h91; 8'h82: y = 8'h11; 8'h83: y = 8'h41;
      8'h84: y = 8'h4f; 8'h85: y = 8'h67; 8'h86: y = 8'hdc; 8'h87: y = 8'hea;
      8'h88: y = 8'h97; 8'h89: y = 8'hf2; 8'h8a: y = 8'hcf; 8'h8b: y = 8'hce;
      8'h8c: y = 8'hf0; 8'h8d: y = 8'hb4; 8'h8e: y = 8'he6; 8'h8f: y = 8'h73;
      8'h90: y = 8'h96; 8'h91: y = 8'hac; 8'h92: y = 8'h74; 8'h93: y = 8'h22;
      8'h94: y = 8'he7; 8'h95: y = 8'had; 8'h96: y = 8'h35; 8'h97: y = 8'h85;
      8'h98: y = 8'he2; 8'h99: y = 8'hf9; 8'h9a: y = 8'h37; 8'h9b: y = 8'he8;
      8'h9c: y = 8'h1c; 8'h9d: y = 8'h75; 8'h9e: y = 8'hdf; 8'h9f: y = 8'h6e;
      8'ha0: y = 8'h47; 8'ha1: y = 8'hf1; 8'ha2: y = 8'h1a; 8'ha3: y = 8'h71;
      8'ha4: y = 8'h1d; 8'ha5: y = 8'h29; 8'ha6: y = 8'hc5; 8'ha7: y = 8'h89;
      8'ha8: y = 8'h6f; 8'ha9: y = 8'hb7; 8'haa: y = 8'h62; 8'hab: y = 8'h0e;
      8'hac: y = 8'haa; 8'had: y = 8'h18; 8'hae: y = 8'hbe; 8'haf: y = 8'h1b;
      8'hb0: y = 8'hfc; 8'hb1: y = 8'h56; 8'hb2: y = 8'h3e; 8'hb3: y = 8'h4b;
      8'hb4: y = 8'hc6; 8'hb5: y = 8'hd2; 8'hb6: y = 8'h79; 8'hb7: y = 8'h20;
      8'hb8: y = 8'h9a; 8'hb9: y = 8'hdb; 8'hba: y = 8'hc0; 8'hbb: y = 8'hfe;
      8'hbc: y = 8'h78; 8'hbd: y = 8'hcd; 8'hbe: y = 8'h5a; 8'hbf: y = 8'hf4;
      8'hc0: y = 8'h1f; 8'hc1: y = 8'hdd; 8'hc2: y = 8'ha8; 8'hc3: y = 8'h33;
      8'hc4: y = 8'h88; 8'hc5: y = 8'h07; 8'hc6: y = 8'hc7; 8'hc7: y = 8'h31;
      8'hc8: y = 8'hb1; 8'hc9: y = 8'h12; 8'hca: y = 8'h10; 8'hcb: y = 8'h59;
      8'hcc: y = 8'h27; 8'hcd: y = 8'h80; 8'hce: y = 8'hec; 8'hcf: y = 8'h5f;
      8'hd0: y = 8'h60; 8'hd1: y = 8'h51; 8'hd2: y = 8'h7f; 8'hd3: y = 8'ha9;
      8'hd4: y = 8'h19; 8'hd5: y = 8'hb5; 8'hd6: y = 8'h4a; 8'hd7: y = 8'h0d;
      8'hd8: y = 8'h2d; 8'hd9: y = 8'he5; 8'hda: y = 8'h7a; 8'hdb: y = 8'h9f;
      8'hdc: y = 8'h93; 8'hdd: y = 8'hc9; 8'hde: y = 8'h9c; 8'hdf: y = 8'hef;
      8'he0: y = 8'ha0; 8'he1: y = 8'he0; 8'he2: y = 8'h3b; 8'he3: y = 8'h4d;
      8'he4: y = 8'hae; 8'he5: y = 8'h2a; 8'he6: y = 8'hf5; 8'he7: y = 8'hb0;
      8'he8: y = 8'hc8; 8'he9: y = 8'heb; 8'hea: y = 8'hbb; 8'heb: y = 8'h3c;
      8'hec: y = 8'h83; 8'hed: y = 8'h53; 8'hee: y = 8'h99; 8'hef: y = 8'h61;
      8'hf0: y = 8'h17; 8'hf1: y = 8'h2b; 8'hf2: y = 8'h04; 8'hf3: y = 8'h7e;
      8'hf4: y = 8'hba; 8'hf5: y = 8'h77; 8'hf6: y = 8'hd6; 8'hf7: y = 8'h26;
      8'hf8: y = 8'he1; 8'hf9: y = 8'h69; 8'hfa: y = 8'h14; 8'hfb: y = 8'h63;
      8'hfc: y = 8'h55; 8'hfd: y = 8'h21; 8'hfe: y = 8'h0c; 8'hff: y = 8'h7d;
    endcase
  end

endmodule

module inv_sub_bytes #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int PASSES = 16 / BYTES_PER_CYCLE;
  localparam int CW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CW-1:0] LAST_PASS = CW'(PASSES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [127:0]  st_reg;
  logic [127:0]  st_next;
  logic [CW-1:0] pass_cnt;
  logic [7:0]    lane_in  [BYTES_PER_CYCLE];
  logic [7:0]    lane_out [BYTES_PER_CYCLE];

  // Byte k lives at bit offset 8*(15-k); for a 4-bit k that is {~k, 3'b000}.
  always_comb begin
    logic [3:0] k;
    k = '0;
    for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
      k = 4'(int'(pass_cnt) * BYTES_PER_CYCLE + i);
      lane_in[i] = st_reg[{~k, 3'b000} +: 8];
    end
  end

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
    inv_sbox u_sbox (
      .a (lane_in[g]),
      .y (lane_out[g])
    );
  end

  always_comb begin
    logic [3:0] k;
    k = '0;
    st_next = st_reg;
    for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
      k = 4'(int'(pass_cnt) * BYTES_PER_CYCLE + i);
      st_next[{~k, 3'b000} +: 8] = lane_out[i];
    end
  end

  // Reset mid-block discards it: no out_valid is ever produced for that block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      st_reg   <= '0;
      pass_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st_reg   <= state_in;
            pass_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          st_reg <= st_next;
          if (pass_cnt == LAST_PASS) begin
            pass_cnt <= '0;
            state    <= DONE;
          end else begin
            pass_cnt <= pass_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign state_out = st_reg;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Directed bench for inv_sub_bytes: one instance per legal BYTES_PER_CYCLE
// (1,2,4,8,16), with index 2 (four bytes per cycle) as the main target.

module tb_inv_sub_bytes;

  logic             clk;
  logic             rst_n;
  logic [4:0]       in_valid;
  logic [4:0]       in_ready;
  logic [4:0][127:0] state_in;
  logic [4:0]       out_valid;
  logic [4:0]       out_ready;
  logic [4:0][127:0] state_out;
  logic [4:0]       busy;

  logic [127:0] fwd_rows [16];
  logic [127:0] exp_q [$];
  int check_count;
  int pass_count;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    inv_sub_bytes #(.BYTES_PER_CYCLE(1 << g)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .state_in  (state_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .state_out (state_out[g]),
      .busy      (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  // Block j of the identity sequence: bytes 16j .. 16j+15.
  function automatic logic [127:0] identBlock(input int j);
    logic [127:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) r = {r[119:0], 8'(16 * j + b)};
    return r;
  endfunction

  // Send one block, measure latency, optionally stall the consumer, then hand off.
  task automatic applyStimulus(input int sel, input logic [127:0] din, input logic [127:0] exp,
                               input int exp_lat, input int hold, input string tag);
    int lat;
    @(negedge clk);
    checkOutput({tag, " in_ready idle"}, 128'(in_ready[sel]), 128'(1));
    in_valid[sel] = 1'b1;
    state_in[sel] = din;
    @(posedge clk);
    #1;
    in_valid[sel] = 1'b0;
    state_in[sel] = ~din;
    checkOutput({tag, " in_ready busy"}, 128'(in_ready[sel]), 128'(0));
    checkOutput({tag, " busy"}, 128'(busy[sel]), 128'(1));
    lat = 0;
    while (!out_valid[sel] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 128'(lat), 128'(exp_lat));
    checkOutput({tag, " data"}, state_out[sel], exp);
    for (int h = 0; h < hold; h++) begin
      in_valid[sel] = 1'b1;
      state_in[sel] = 128'(h) ^ din;
      @(posedge clk);
      #1;
      checkOutput({tag, " hold out_valid"}, 128'(out_valid[sel]), 128'(1));
      checkOutput({tag, " hold data"}, state_out[sel], exp);
      checkOutput({tag, " hold in_ready"}, 128'(in_ready[sel]), 128'(0));
      checkOutput({tag, " hold busy"}, 128'(busy[sel]), 128'(1));
    end
    in_valid[sel]  = 1'b0;
    out_ready[sel] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[sel] = 1'b0;
    checkOutput({tag, " handoff in_ready"}, 128'(in_ready[sel]), 128'(1));
    checkOutput({tag, " handoff out_valid"}, 128'(out_valid[sel]), 128'(0));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [127:0] cur_exp;
    int cyc;
    int outs;
    int accepts;
    int last_accept;

    fwd_rows = '{
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    check_count = 0;
    pass_count  = 0;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    state_in  = '0;

    #12;
    checkOutput("reset out_valid", 128'(out_valid[2]), 128'(0));
    checkOutput("reset busy", 128'(busy[2]), 128'(0));
    checkOutput("reset state_out", state_out[2], 128'h0);
    checkOutput("reset in_ready", 128'(in_ready[2]), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(2, {16{8'h63}}, 128'h0, 4, 0, "all63");

    for (int g = 0; g < 5; g++) begin
      applyStimulus(g, fwd_rows[0], 128'h000102030405060708090a0b0c0d0e0f, 16 >> g, 0,
                    $sformatf("pair bpc%0d", 1 << g));
    end

    for (int j = 0; j < 16; j++) begin
      applyStimulus(2, fwd_rows[j], identBlock(j), 4, 0, $sformatf("exhaustive %0d", j));
    end
    applyStimulus(2, 128'h520016ed637c_63636363636363636363,
                  128'h4852ff530001_00000000000000000000, 4, 0, "spot");

    applyStimulus(2, fwd_rows[5], identBlock(5), 4, 10, "backpressure");

    // Abort a block two edges after acceptance.
    @(negedge clk);
    in_valid[2] = 1'b1;
    state_in[2] = fwd_rows[3];
    @(posedge clk);
    #1;
    in_valid[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", 128'(out_valid[2]), 128'(0));
    checkOutput("midreset state_out", state_out[2], 128'h0);
    checkOutput("midreset in_ready", 128'(in_ready[2]), 128'(1));
    checkOutput("midreset busy", 128'(busy[2]), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2, {16{8'h63}}, 128'h0, 4, 0, "after reset");

    // Streaming with both handshakes held open.
    cyc = 0;
    outs = 0;
    accepts = 0;
    last_accept = 0;
    exp_q.delete();
    out_ready[2] = 1'b1;
    in_valid[2]  = 1'b1;
    while (outs < 5 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid[2]) begin
        if (exp_q.size() == 0) begin
          checkOutput("stream extra out_valid", 128'(out_valid[2]), 128'(0));
        end else begin
          cur_exp = exp_q.pop_front();
          checkOutput("stream data", state_out[2], cur_exp);
        end
        outs++;
        if (outs == 5) in_valid[2] = 1'b0;
      end
      if (in_ready[2] && in_valid[2]) begin
        if (accepts > 0) checkOutput("stream spacing", 128'(cyc - last_accept), 128'(6));
        last_accept = cyc;
        state_in[2] = fwd_rows[accepts + 8];
        exp_q.push_back(identBlock(accepts + 8));
        accepts++;
      end
    end
    checkOutput("stream outputs", 128'(outs), 128'(5));
    checkOutput("stream accepts", 128'(accepts), 128'(5));
    @(posedge clk);
    #1;
    out_ready[2] = 1'b0;
    checkOutput("stream end in_ready", 128'(in_ready[2]), 128'(1));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
